// File: rtl/prism_sp_puzzle_hw_endpoint_if.sv
// Puzzle FIFO access interfaces: a non-FWFT read side and a plain write side.
interface fifo_read_interface;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  modport master (output rd_en, input rd_data, input empty);
  modport slave  (input rd_en, output rd_data, output empty);
endinterface

interface fifo_write_interface;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  modport master (output wr_en, output wr_data, input full);
  modport slave  (input wr_en, input wr_data, output full);
endinterface

// File: rtl/prism_sp_puzzle_hw_endpoint.sv
// Hardware endpoint of the SP puzzle FIFO pair: unframes SP messages into an RX
// stream and frames a buffered TX stream (header first) back to SP.
module prism_sp_puzzle_hw_endpoint #(
  parameter int DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  fifo_read_interface.master  sp2hw_fifo_r,
  fifo_write_interface.master hw2sp_fifo_w,
  output logic [31:0]         m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [6:0]          m_opcode,
  output logic [7:0]          m_tag,
  input  logic [31:0]         s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [6:0]          s_opcode,
  input  logic [7:0]          s_tag,
  output logic                rx_busy,
  output logic                tx_busy
);

  localparam int          CW       = $clog2(DEPTH);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);
  localparam logic [CW:0] ONE      = (CW+1)'(1);

  // Handshakes: a beat moves when valid & ready are both high at a rising clk;
  // valid never waits on ready, and payload/sideband hold while valid & !ready.

  typedef enum logic {RX_HDR, RX_PAY} rx_state_t;
  rx_state_t   rx_state;
  logic        hdr_pending;
  logic        pay_pending;
  logic [16:0] reads_left;
  logic [15:0] ld_rem;
  logic        pay_rd_ok;
  logic        rx_rd_en;

  // The returning header word does not block the first payload read; a payload
  // word in flight does, which is what limits RX to one word per two cycles.
  assign pay_rd_ok = (rx_state == RX_PAY) && !pay_pending &&
                     (hdr_pending || reads_left != 17'd0) && (!m_tvalid || m_tready);
  assign rx_rd_en  = !rst && !sp2hw_fifo_r.empty && ((rx_state == RX_HDR) || pay_rd_ok);
  assign sp2hw_fifo_r.rd_en = rx_rd_en;
  assign rx_busy = (rx_state == RX_PAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_HDR;
      hdr_pending <= 1'b0;
      pay_pending <= 1'b0;
      reads_left  <= 17'd0;
      ld_rem      <= 16'd0;
      m_tdata     <= 32'd0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_opcode    <= 7'd0;
      m_tag       <= 8'd0;
    end else begin
      hdr_pending <= 1'b0;
      pay_pending <= rx_rd_en && (rx_state == RX_PAY);
      case (rx_state)
        RX_HDR: begin
          if (rx_rd_en) begin
            rx_state    <= RX_PAY;
            hdr_pending <= 1'b1;
          end
        end
        RX_PAY: begin
          if (hdr_pending) begin
            m_opcode   <= sp2hw_fifo_r.rd_data[30:24];
            m_tag      <= sp2hw_fifo_r.rd_data[23:16];
            ld_rem     <= sp2hw_fifo_r.rd_data[15:0];
            reads_left <= {1'b0, sp2hw_fifo_r.rd_data[15:0]} + 17'd1 - {16'd0, rx_rd_en};
          end else if (rx_rd_en) begin
            reads_left <= reads_left - 17'd1;
          end
          if (pay_pending) begin
            m_tdata  <= sp2hw_fifo_r.rd_data;
            m_tvalid <= 1'b1;
            m_tlast  <= (ld_rem == 16'd0);
            ld_rem   <= ld_rem - 16'd1;
          end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            if (m_tlast) rx_state <= RX_HDR;
          end
        end
      endcase
    end
  end

  typedef enum logic [1:0] {TX_FILL, TX_DISCARD, TX_HDR, TX_DRAIN} tx_state_t;
  tx_state_t   tx_state;
  logic [31:0] tx_buf [DEPTH];
  logic [CW:0] cnt;
  logic [CW:0] rd_ptr;
  logic        trunc;
  logic [6:0]  tx_opcode;
  logic [7:0]  tx_tag;
  logic [31:0] pf_data;
  logic [15:0] len_m1;
  logic        s_beat;
  logic        buf_we;
  logic        tx_wr_en;

  assign s_tready = !rst && (tx_state == TX_FILL || tx_state == TX_DISCARD);
  assign s_beat   = s_tvalid && s_tready;
  assign buf_we   = s_beat && (tx_state == TX_FILL) && (cnt != FULL_CNT);
  assign len_m1   = 16'(cnt - ONE);
  assign tx_wr_en = !rst && !hw2sp_fifo_w.full && (tx_state == TX_HDR || tx_state == TX_DRAIN);
  assign hw2sp_fifo_w.wr_en   = tx_wr_en;
  assign hw2sp_fifo_w.wr_data = (tx_state == TX_HDR) ? {trunc, tx_opcode, tx_tag, len_m1} : pf_data;
  assign tx_busy = (tx_state != TX_FILL) || (cnt != '0);

  // pf_data always holds the next payload word, so draining never bubbles.
  always_ff @(posedge clk) begin
    if (buf_we) tx_buf[cnt[CW-1:0]] <= s_tdata;
    if (tx_state == TX_HDR) pf_data <= tx_buf[0];
    else if (tx_state == TX_DRAIN && tx_wr_en) pf_data <= tx_buf[rd_ptr[CW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_FILL;
      cnt       <= '0;
      rd_ptr    <= '0;
      trunc     <= 1'b0;
      tx_opcode <= 7'd0;
      tx_tag    <= 8'd0;
    end else begin
      case (tx_state)
        TX_FILL: begin
          if (s_beat) begin
            if (cnt == FULL_CNT) begin
              trunc    <= 1'b1;
              tx_state <= s_tlast ? TX_HDR : TX_DISCARD;
            end else begin
              cnt <= cnt + ONE;
              if (cnt == '0) begin
                tx_opcode <= s_opcode;
                tx_tag    <= s_tag;
              end
              if (s_tlast) tx_state <= TX_HDR;
            end
          end
        end
        TX_DISCARD: begin
          if (s_beat && s_tlast) tx_state <= TX_HDR;
        end
        TX_HDR: begin
          rd_ptr <= ONE;
          if (tx_wr_en) tx_state <= TX_DRAIN;
        end
        TX_DRAIN: begin
          if (tx_wr_en) begin
            rd_ptr <= rd_ptr + ONE;
            if (rd_ptr == cnt) begin
              cnt      <= '0;
              trunc    <= 1'b0;
              tx_state <= TX_FILL;
            end
          end
        end
      endcase
    end
  end

endmodule
